// File: rtl/syzygy_adc_align_seq.sv
// -----------------------------------------------------------------------------
// syzygy_adc_align_seq
//
// Startup sequencer and frame aligner for a serial LVDS ADC front end. It
// releases the IDELAYCTRL and ISERDES resets in order once the MMCM is locked.
// It then trains word alignment by pulsing bitslip until the deserialised frame
// word equals FRAME_PATTERN. Once aligned it passes sample data through with a
// valid flag, watches the frame lane, and retrains when alignment is lost.
// Everything runs in the divided ADC data clock domain.
//
// Ports
//   clk            divided ADC data clock
//   reset_async_n  asynchronous active-low reset
//   mmcm_locked    async MMCM lock, 2-flop synchronised
//   idelay_rdy     async IDELAYCTRL ready, 2-flop synchronised
//   retrain        single-cycle realign request
//   frame_word     deserialised frame lane
//   adc_data_in    deserialised channel words, channel 0 in the LSBs
//   reset_idelay   IDELAYCTRL reset
//   reset_serdes   ISERDES / IDELAY reset
//   bitslip        one-cycle bitslip pulse
//   bitslip_count  cumulative slips modulo DATA_WIDTH
//   adc_data_out   registered sample data
//   data_valid     adc_data_out is aligned and valid
//   rdy            sequencer is in LOCKED
//   align_error    training exhausted MAX_SLIPS
//   relock_count   automatic retrains, saturating at 255
// -----------------------------------------------------------------------------
module syzygy_adc_align_seq #(
  parameter int                    NUM_CHANNELS    = 2,
  parameter int                    DATA_WIDTH      = 16,
  parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN   = 16'hFF00,
  parameter int                    SETTLE_CYCLES   = 64,
  parameter int                    BITSLIP_WAIT    = 4,
  parameter int                    MAX_SLIPS       = 15,
  parameter int                    LOCK_LOSS_COUNT = 4
) (
  input  logic                               clk,
  input  logic                               reset_async_n,
  input  logic                               mmcm_locked,
  input  logic                               idelay_rdy,
  input  logic                               retrain,
  input  logic [DATA_WIDTH-1:0]              frame_word,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] adc_data_in,
  output logic                               reset_idelay,
  output logic                               reset_serdes,
  output logic                               bitslip,
  output logic [$clog2(DATA_WIDTH)-1:0]      bitslip_count,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] adc_data_out,
  output logic                               data_valid,
  output logic                               rdy,
  output logic                               align_error,
  output logic [7:0]                         relock_count
);

  localparam int BSC_W   = $clog2(DATA_WIDTH);
  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam int CNT_MAX = (SETTLE_CYCLES > BITSLIP_WAIT) ? SETTLE_CYCLES : BITSLIP_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MISS_W  = $clog2(LOCK_LOSS_COUNT + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  WAIT_LD   = CNT_W'(BITSLIP_WAIT);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(MAX_SLIPS);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOCK_LOSS_COUNT - 1);
  localparam logic [BSC_W-1:0]  BSC_LAST  = BSC_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_RESET_HOLD  = 3'd0;
  localparam logic [2:0] S_WAIT_IDELAY = 3'd1;
  localparam logic [2:0] S_SETTLE      = 3'd2;
  localparam logic [2:0] S_CHECK       = 3'd3;
  localparam logic [2:0] S_SLIP        = 3'd4;
  localparam logic [2:0] S_SLIP_WAIT   = 3'd5;
  localparam logic [2:0] S_LOCKED      = 3'd6;
  localparam logic [2:0] S_FAIL        = 3'd7;

  logic              mmcm_p0, mmcm_p1;
  logic              idly_p0, idly_p1;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [SLIP_W-1:0] slips;
  logic [MISS_W-1:0] miss;
  logic              frame_match;
  logic              retrain_ok;

  assign frame_match = (frame_word == FRAME_PATTERN);
  // Retrain only means something once the PHY is out of reset and settled.
  assign retrain_ok  = (state == S_CHECK) || (state == S_SLIP) || (state == S_SLIP_WAIT) ||
                       (state == S_LOCKED) || (state == S_FAIL);

  always_ff @(posedge clk or negedge reset_async_n) begin
    if (!reset_async_n) begin
      mmcm_p0       <= 1'b0;
      mmcm_p1       <= 1'b0;
      idly_p0       <= 1'b0;
      idly_p1       <= 1'b0;
      state         <= S_RESET_HOLD;
      cnt           <= '0;
      slips         <= '0;
      miss          <= '0;
      reset_idelay  <= 1'b1;
      reset_serdes  <= 1'b1;
      bitslip       <= 1'b0;
      bitslip_count <= '0;
      adc_data_out  <= '0;
      data_valid    <= 1'b0;
      rdy           <= 1'b0;
      align_error   <= 1'b0;
      relock_count  <= 8'd0;
    end else begin
      // Stage p0 -> p1: two-flop synchronisers for the asynchronous status inputs
      mmcm_p0 <= mmcm_locked;
      mmcm_p1 <= mmcm_p0;
      idly_p0 <= idelay_rdy;
      idly_p1 <= idly_p0;

      // Output stage: sample data and its valid flag, one cycle behind the inputs
      adc_data_out <= adc_data_in;
      data_valid   <= mmcm_p1 && (state == S_LOCKED) && frame_match;

      bitslip <= 1'b0;

      if (!mmcm_p1) begin
        // Clock loss restarts the whole bring-up; slip and relock history survive.
        state        <= S_RESET_HOLD;
        cnt          <= '0;
        slips        <= '0;
        miss         <= '0;
        reset_idelay <= 1'b1;
        reset_serdes <= 1'b1;
        rdy          <= 1'b0;
        align_error  <= 1'b0;
      end else if (retrain && retrain_ok) begin
        state       <= S_CHECK;
        slips       <= '0;
        miss        <= '0;
        rdy         <= 1'b0;
        align_error <= 1'b0;
      end else begin
        case (state)
          S_RESET_HOLD: begin
            state        <= S_WAIT_IDELAY;
            reset_idelay <= 1'b0;
          end
          S_WAIT_IDELAY: begin
            if (idly_p1) begin
              state        <= S_SETTLE;
              reset_serdes <= 1'b0;
              cnt          <= SETTLE_LD;
            end
          end
          S_SETTLE: begin
            // Counter was loaded on entry, so leaving at 1 gives SETTLE_CYCLES cycles here.
            if (cnt <= CNT_W'(1)) begin
              state <= S_CHECK;
              slips <= '0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_CHECK: begin
            if (frame_match) begin
              state <= S_LOCKED;
              miss  <= '0;
              rdy   <= 1'b1;
            end else if (slips == SLIP_LAST) begin
              state       <= S_FAIL;
              align_error <= 1'b1;
            end else begin
              state         <= S_SLIP;
              bitslip       <= 1'b1;
              slips         <= slips + SLIP_W'(1);
              bitslip_count <= (bitslip_count == BSC_LAST) ? '0 : bitslip_count + BSC_W'(1);
            end
          end
          S_SLIP: begin
            state <= S_SLIP_WAIT;
            cnt   <= WAIT_LD;
          end
          S_SLIP_WAIT: begin
            if (cnt <= CNT_W'(1)) begin
              state <= S_CHECK;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_LOCKED: begin
            if (frame_match) begin
              miss <= '0;
            end else if (miss == MISS_LAST) begin
              state <= S_CHECK;
              slips <= '0;
              miss  <= '0;
              rdy   <= 1'b0;
              if (relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
            end else begin
              miss <= miss + MISS_W'(1);
            end
          end
          S_FAIL: begin
            align_error <= 1'b1;
          end
          default: state <= S_RESET_HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_syzygy_adc_align_seq.sv
// -----------------------------------------------------------------------------
// Bench for syzygy_adc_align_seq. A driver applies directed stimulus on the
// falling edge and queues the sample word it expects to see flagged valid; a
// monitor after each rising edge pops and compares whenever data_valid is high.
// A second instance covers a 4-channel, 14-bit configuration.
// -----------------------------------------------------------------------------
module tb_syzygy_adc_align_seq;

  localparam logic [15:0] PAT  = 16'hFF00;
  localparam logic [15:0] BAD  = 16'h1234;
  localparam logic [13:0] PAT2 = 14'h3F80;
  localparam logic [13:0] BAD2 = 14'h0155;

  logic        clk = 1'b0;
  logic        rst_n, mmcm, idly, retrain;
  logic [15:0] frame_word;
  logic [31:0] adc_in, adc_out;
  logic        reset_idelay, reset_serdes, bitslip, data_valid, rdy, align_error;
  logic [3:0]  bsc;
  logic [7:0]  relock;

  logic        s_rst_n, s_mmcm, s_idly, s_retrain;
  logic [13:0] s_frame;
  logic [55:0] s_adc_in, s_adc_out;
  logic        s_ri, s_rs, s_bitslip, s_dv, s_rdy, s_ae;
  logic [3:0]  s_bsc;
  logic [7:0]  s_relock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int s_pulses = 0;
  int pulse_time[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_d;
  logic exp_locked;
  int mark, target, e0, rdy_cyc;

  always #5 clk = ~clk;

  syzygy_adc_align_seq dut (
    .clk(clk), .reset_async_n(rst_n), .mmcm_locked(mmcm), .idelay_rdy(idly),
    .retrain(retrain), .frame_word(frame_word), .adc_data_in(adc_in),
    .reset_idelay(reset_idelay), .reset_serdes(reset_serdes), .bitslip(bitslip),
    .bitslip_count(bsc), .adc_data_out(adc_out), .data_valid(data_valid),
    .rdy(rdy), .align_error(align_error), .relock_count(relock)
  );

  syzygy_adc_align_seq #(
    .NUM_CHANNELS(4), .DATA_WIDTH(14), .FRAME_PATTERN(PAT2), .SETTLE_CYCLES(3),
    .BITSLIP_WAIT(2), .MAX_SLIPS(15), .LOCK_LOSS_COUNT(2)
  ) dut2 (
    .clk(clk), .reset_async_n(s_rst_n), .mmcm_locked(s_mmcm), .idelay_rdy(s_idly),
    .retrain(s_retrain), .frame_word(s_frame), .adc_data_in(s_adc_in),
    .reset_idelay(s_ri), .reset_serdes(s_rs), .bitslip(s_bitslip),
    .bitslip_count(s_bsc), .adc_data_out(s_adc_out), .data_valid(s_dv),
    .rdy(s_rdy), .align_error(s_ae), .relock_count(s_relock)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Frame model of a lane that becomes aligned after `target` slips since `mark`.
  function automatic logic [15:0] auto_frame();
    return ((pulses - mark) >= target) ? PAT : BAD;
  endfunction

  task automatic step(input logic [31:0] d, input logic [15:0] f);
    adc_in     = d;
    frame_word = f;
    if (exp_locked && f == PAT) exp_q.push_back(d);
    @(negedge clk);
  endtask

  // Monitor: pulse bookkeeping and scoreboard, sampled just after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (bitslip) begin
      pulses = pulses + 1;
      pulse_time.push_back(cyc);
    end
    if (s_bitslip) s_pulses = s_pulses + 1;
    if (data_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", data_valid, 0);
      else begin
        exp_d = exp_q.pop_front();
        check("adc_data_out", adc_out, exp_d);
      end
    end else if (exp_q.size() != 0) begin
      exp_d = exp_q.pop_front();
      check("missing_valid", data_valid, 1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vecs[4];
    bit seen13;
    vecs = '{32'h0001_0002, 32'hFFFF_0000, 32'h8000_7FFF, 32'hA5A5_5A5A};
    rst_n = 0; mmcm = 0; idly = 0; retrain = 0; frame_word = BAD; adc_in = 32'hDEAD_BEEF;
    s_rst_n = 0; s_mmcm = 0; s_idly = 0; s_retrain = 0; s_frame = BAD2; s_adc_in = '0;
    exp_locked = 0; mark = 0; target = 0; seen13 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_flags", {reset_idelay, reset_serdes, bitslip, data_valid, rdy, align_error}, 6'b110000);
    check("rst_bsc", bsc, 0);
    check("rst_relock", relock, 0);
    check("rst_adc_out", adc_out, 0);

    // Bring-up sequencing
    rst_n = 1;
    step(32'h0, BAD);
    step(32'h0, BAD);
    check("hold_no_mmcm", reset_idelay, 1);
    mmcm = 1;
    step(32'h0, BAD);
    step(32'h0, BAD);
    check("ri_after_2", reset_idelay, 1);
    step(32'h0, BAD);
    check("ri_after_3", reset_idelay, 0);
    check("rs_wait_idelay", reset_serdes, 1);
    idly = 1;
    step(32'h0, BAD);
    step(32'h0, BAD);
    check("rs_after_2", reset_serdes, 1);
    step(32'h0, BAD);
    check("rs_after_3", reset_serdes, 0);
    e0 = cyc;

    // Alignment after 5 slips
    mark = pulses; target = 5;
    for (int i = 0; i < 200 && !rdy; i++) step(32'h100 + 32'(i), auto_frame());
    rdy_cyc = cyc;
    check("rdy_after_align", rdy, 1);
    exp_locked = 1;
    check("align_pulses", pulses, 5);
    check("settle_to_first_slip", pulse_time[0] - e0, 65);
    for (int i = 1; i < 5; i++) check("slip_spacing", pulse_time[i] - pulse_time[i-1], 6);
    check("rdy_after_last_slip", rdy_cyc - pulse_time[4], 6);
    check("align_bsc", bsc, 5);
    check("align_err_low", align_error, 0);

    // Data path through the scoreboard
    for (int i = 0; i < 4; i++) step(vecs[i], PAT);

    // Three misses then a match keep lock
    step(32'h1111_1111, BAD);
    step(32'h2222_2222, BAD);
    step(32'h3333_3333, BAD);
    step(32'h4444_4444, PAT);
    check("lock_held_rdy", rdy, 1);
    check("lock_held_relock", relock, 0);
    step(32'h5555_5555, PAT);

    // Four consecutive misses drop lock and retrain
    step(32'h6666_6666, BAD);
    step(32'h7777_7777, BAD);
    step(32'h8888_8888, BAD);
    check("rdy_before_4th", rdy, 1);
    step(32'h9999_9999, BAD);
    exp_locked = 0;
    check("rdy_lock_loss", rdy, 0);
    check("relock_1", relock, 1);
    mark = pulses; target = 2;
    for (int i = 0; i < 100 && !rdy; i++) step(32'h200 + 32'(i), auto_frame());
    check("relock_rdy", rdy, 1);
    exp_locked = 1;
    check("relock_pulses", pulses - mark, 2);
    check("relock_bsc", bsc, 7);
    step(32'hCAFE_F00D, PAT);
    step(32'h0BAD_BEEF, PAT);

    // Manual retrain into a lane that never aligns
    retrain = 1;
    step(32'h0, BAD);
    retrain = 0;
    exp_locked = 0;
    check("retrain_rdy_low", rdy, 0);
    check("retrain_no_relock", relock, 1);
    mark = pulses; target = 1000;
    for (int i = 0; i < 200 && !align_error; i++) step(32'h0, auto_frame());
    check("fail_align_error", align_error, 1);
    check("fail_pulses", pulses - mark, 15);
    check("fail_rdy", rdy, 0);
    check("fail_bsc", bsc, 6);
    mark = pulses;
    repeat (5) step(32'h0, BAD);
    check("fail_no_more_slips", pulses - mark, 0);

    // Retrain out of FAIL restarts slipping
    retrain = 1;
    step(32'h0, BAD);
    retrain = 0;
    check("retrain_clears_err", align_error, 0);
    mark = pulses;
    step(32'h0, BAD);
    check("retrain_slips", pulses - mark, 1);
    check("retrain_bsc", bsc, 7);

    // MMCM loss during SLIP_WAIT
    step(32'h0, BAD);
    mmcm = 0;
    step(32'h0, BAD);
    step(32'h0, BAD);
    check("mmcm_loss_sync_delay", reset_idelay, 0);
    step(32'h0, BAD);
    check("mmcm_loss_flags", {reset_idelay, reset_serdes, rdy, align_error}, 4'b1100);
    check("mmcm_loss_bsc_held", bsc, 7);
    check("mmcm_loss_relock_held", relock, 1);

    // Asynchronous reset mid-SETTLE
    mmcm = 1;
    for (int i = 0; i < 20 && reset_serdes; i++) step(32'h0, BAD);
    check("rebringup_rs", reset_serdes, 0);
    adc_in = 32'h1234_5678;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_flags", {reset_idelay, reset_serdes, bitslip, data_valid, rdy, align_error}, 6'b110000);
    check("async_rst_bsc", bsc, 0);
    check("async_rst_relock", relock, 0);
    check("async_rst_adc", adc_out, 0);
    @(negedge clk);

    // Parameter sweep: 4 channels of 14 bits, slip count wraps 13 -> 0
    s_rst_n = 1; s_mmcm = 1; s_idly = 1;
    for (int i = 0; i < 300 && !s_rdy; i++) begin
      @(negedge clk);
      s_frame = (s_pulses >= 14) ? PAT2 : BAD2;
      if (s_pulses == 13 && !seen13) begin
        seen13 = 1;
        check("sw_bsc_13", s_bsc, 13);
      end
    end
    check("sw_rdy", s_rdy, 1);
    check("sw_pulses", s_pulses, 14);
    check("sw_bsc_wrap", s_bsc, 0);
    s_adc_in = {14'h3FFF, 14'h1555, 14'h0ABC, 14'h0001};
    @(negedge clk);
    check("sw_ch0", s_adc_out[13:0], 14'h0001);
    check("sw_ch1", s_adc_out[27:14], 14'h0ABC);
    check("sw_ch2", s_adc_out[41:28], 14'h1555);
    check("sw_ch3", s_adc_out[55:42], 14'h3FFF);
    check("sw_valid", s_dv, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/syzygy_adc_align_seq.md
# syzygy_adc_align_seq

Parametrised startup sequencer and frame aligner for serial LVDS ADC front ends with any number of data channels. It sequences IDELAYCTRL and ISERDES resets from MMCM lock, trains word alignment by issuing bitslip pulses until the deserialised frame word matches a programmable pattern, and then gates per-channel sample data. While locked, it monitors the frame continuously and retrains automatically when lock is lost. It sits between the DCO clock module, the per-lane PHYs and the frame deserialiser, and runs entirely in the divided ADC data clock domain.

## Interface
- NUM_CHANNELS, 2: number of ADC data channels.
- DATA_WIDTH, 16: bits per deserialised word, for both frame and data.
- FRAME_PATTERN, 16'hFF00: expected frame word when aligned (DATA_WIDTH bits).
- SETTLE_CYCLES, 64: wait after ISERDES reset release before training starts (≥1).
- BITSLIP_WAIT, 4: cycles held after each bitslip pulse before re-checking (≥1).
- MAX_SLIPS, 15: slips attempted before declaring failure.
- LOCK_LOSS_COUNT, 4: consecutive frame mismatches while locked that trigger retraining (≥1).

- clk  in  1  divided ADC data clock; the block's only clock.
- reset_async_n  in  1  asynchronous, active-low reset.
- mmcm_locked  in  1  asynchronous; 2-flop synchronised internally.
- idelay_rdy  in  1  asynchronous IDELAYCTRL ready; 2-flop synchronised internally.
- retrain  in  1  single-cycle request to realign.
- frame_word  in  DATA_WIDTH  deserialised frame lane.
- adc_data_in  in  NUM_CHANNELS*DATA_WIDTH  deserialised channel words, channel 0 in the LSBs.
- reset_idelay  out  1  IDELAYCTRL reset.
- reset_serdes  out  1  ISERDES/IDELAY reset.
- bitslip  out  1  one-cycle bitslip pulse.
- bitslip_count  out  $clog2(DATA_WIDTH)  cumulative slips, modulo DATA_WIDTH.
- adc_data_out  out  NUM_CHANNELS*DATA_WIDTH  registered sample data.
- data_valid  out  1  adc_data_out is aligned and valid.
- rdy  out  1  block is in LOCKED.
- align_error  out  1  training exhausted MAX_SLIPS.
- relock_count  out  8  count of automatic retrains; saturates at 255.

## Operation
- All outputs are registered.
- Reset values: reset_idelay=1 and reset_serdes=1. All other outputs, the synchronisers and all counters reset to 0. State resets to RESET_HOLD.
- RESET_HOLD: reset_idelay=1, reset_serdes=1. When synced mmcm_locked=1, go to WAIT_IDELAY and set reset_idelay=0.
- WAIT_IDELAY: reset_serdes stays 1. When synced idelay_rdy=1, go to SETTLE, set reset_serdes=0 and load the settle counter with SETTLE_CYCLES.
- SETTLE: decrement the counter each cycle. At 0, go to CHECK with slips=0.
- CHECK: compare frame_word to FRAME_PATTERN.
  - Match: go to LOCKED.
  - Mismatch with slips==MAX_SLIPS: go to FAIL.
  - Otherwise: go to SLIP.
- SLIP: bitslip=1 for this one cycle. Increment slips and bitslip_count (wrapping DATA_WIDTH-1→0). Load the wait counter with BITSLIP_WAIT and go to SLIP_WAIT.
- SLIP_WAIT: count down. At 0, go to CHECK.
- LOCKED: rdy=1.
  - Each cycle, a mismatch increments the miss counter and a match clears it.
  - When the miss counter reaches LOCK_LOSS_COUNT: go to CHECK, slips=0, rdy=0, relock_count+1 (saturating).
- FAIL: align_error=1. Holds until retrain.
- retrain in LOCKED, FAIL, CHECK, SLIP or SLIP_WAIT:
  - go to CHECK with slips=0 and clear align_error and the miss counter;
  - relock_count is not incremented;
  - retrain is ignored in RESET_HOLD, WAIT_IDELAY and SETTLE.
- Synced mmcm_locked=0 in any state returns the block to RESET_HOLD.
  - All outputs take their reset values, except bitslip_count and relock_count, which hold.
- Priority: mmcm loss > retrain > lock-loss/normal transitions.
- adc_data_out registers adc_data_in every cycle regardless of state.
- data_valid = registered (state==LOCKED && frame_word==FRAME_PATTERN). It is 0 on a mismatching cycle even before lock-loss triggers.

## Timing
- The synchronisers add 2 cycles.
  - reset_idelay falls 3 rising edges after mmcm_locked is first sampled high.
  - reset_serdes falls 3 edges after idelay_rdy is first sampled high.
- SETTLE occupies exactly SETTLE_CYCLES cycles.
- Each failed check costs 2+BITSLIP_WAIT cycles (CHECK, SLIP, wait). With defaults: 6.
- Consecutive bitslip pulses are therefore ≥BITSLIP_WAIT+2 cycles apart.
- The first rdy=1 is on the cycle after the matching CHECK.
- adc_data_out and data_valid: latency 1 from the inputs.
- Lock loss: rdy falls on the edge after the LOCK_LOSS_COUNT-th consecutive mismatch is sampled.

## Test plan
- Reset and bring-up:
  - reset_async_n low → reset_idelay=1, reset_serdes=1, all other outputs 0;
  - mmcm_locked high → reset_idelay=0 after 3 edges;
  - idelay_rdy high → reset_serdes=0 after 3 edges;
  - SETTLE lasts 64 cycles.
- Alignment: frame_word matches only after 5 slips → exactly 5 bitslip pulses, 6 cycles apart; bitslip_count=5; rdy=1; data_valid follows adc_data_in with 1-cycle latency.
- Failure: frame_word never matches → 15 pulses, then align_error=1 and rdy=0; a retrain pulse clears align_error and restarts slipping.
- Lock loss: in LOCKED, 3 mismatches then 1 match → stays locked with data_valid low for 3 cycles; 4 consecutive mismatches → rdy=0, relock_count=1, retraining starts.
- Mid-operation reset: mmcm_locked drops during SLIP_WAIT → RESET_HOLD with reset_idelay=1 and reset_serdes=1 and bitslip_count held; asserting reset_async_n low at any point → all reset values immediately.
- Parameter sweep: NUM_CHANNELS=4, DATA_WIDTH=14, bitslip_count wraps 13→0, channel ordering preserved in adc_data_out.
